// File: rtl/demux_1to2_fifo_pkg.sv
// Shared constants for the 1:2 lane demux: default byte width, lane FIFO depth and lane indices.
package demux_1to2_fifo_pkg;
    localparam int   DEMUX_DATA_W = 8;
    localparam int   DEMUX_DEPTH  = 4;
    localparam logic LANE0        = 1'b0;
    localparam logic LANE1        = 1'b1;
endpackage

// File: rtl/demux_1to2_fifo_fifo.sv
// fifo_sync_L: single-clock first-word-fall-through FIFO with async active-low reset.
// Storage is not reset; the head output is forced to 0 whenever the FIFO is empty.
module fifo_sync_L
    import demux_1to2_fifo_pkg::*;
#(
    parameter  int DATA_W = DEMUX_DATA_W,
    parameter  int DEPTH  = DEMUX_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;
    logic              w_push;

    // A pop on a full FIFO frees the slot in the same cycle, so the push still lands.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/demux_1to2_fifo.sv
// demux_1to2_fifo: de-stripes the muxed byte stream into two lane FIFOs (lane0, lane1, lane0, ...).
// Optional almost-full flags are built only when DEMUX_ALMOST_FULL_EN is defined.
module demux_1to2_fifo
    import demux_1to2_fifo_pkg::*;
#(
    parameter  int DATA_W    = DEMUX_DATA_W,
    parameter  int DEPTH     = DEMUX_DEPTH,
`ifdef DEMUX_ALMOST_FULL_EN
    parameter  int AF_THRESH = 3,
`endif
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              full0,
    output logic              full1,
    output logic              lane_sel,
    output logic              err_overflow,
    output logic              err_underflow
`ifdef DEMUX_ALMOST_FULL_EN
    ,
    output logic              almost_full0,
    output logic              almost_full1
`endif
);
    logic             r_lane_sel;
    logic             r_err_overflow;
    logic             r_err_underflow;
    logic             w_push0;
    logic             w_push1;
    logic             w_empty0;
    logic             w_empty1;
    logic             w_full0;
    logic             w_full1;
    logic             w_drop0;
    logic             w_drop1;
    logic             w_under0;
    logic             w_under1;
    logic [CNT_W-1:0] w_count0;
    logic [CNT_W-1:0] w_count1;

    assign w_push0 = valid_in && (r_lane_sel == LANE0);
    assign w_push1 = valid_in && (r_lane_sel == LANE1);

    // A byte is lost only when its lane is full and the consumer is not draining it this cycle.
    assign w_drop0  = w_push0 && w_full0 && !pop0;
    assign w_drop1  = w_push1 && w_full1 && !pop1;
    assign w_under0 = pop0 && (w_count0 == '0);
    assign w_under1 = pop1 && (w_count1 == '0);

    // lane_sel toggles on every valid byte, dropped or not, to keep even/odd alignment.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_lane_sel      <= LANE0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (valid_in) r_lane_sel <= ~r_lane_sel;
            if (w_drop0 || w_drop1)   r_err_overflow  <= 1'b1;
            if (w_under0 || w_under1) r_err_underflow <= 1'b1;
        end
    end

    fifo_sync_L #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (w_push0),
        .pop     (pop0),
        .din     (data_in),
        .dout    (data_out0),
        .empty   (w_empty0),
        .full    (w_full0),
        .count   (w_count0)
    );

    fifo_sync_L #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (w_push1),
        .pop     (pop1),
        .din     (data_in),
        .dout    (data_out1),
        .empty   (w_empty1),
        .full    (w_full1),
        .count   (w_count1)
    );

    assign valid_out0    = !w_empty0;
    assign valid_out1    = !w_empty1;
    assign full0         = w_full0;
    assign full1         = w_full1;
    assign lane_sel      = r_lane_sel;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

`ifdef DEMUX_ALMOST_FULL_EN
    assign almost_full0 = (w_count0 >= CNT_W'(AF_THRESH));
    assign almost_full1 = (w_count1 >= CNT_W'(AF_THRESH));
`endif
endmodule

// File: tb/tb_demux_1to2_fifo.sv
// Scoreboard bench for demux_1to2_fifo: per-lane expected queues filled as bytes are driven,
// drained and compared as the lane consumers pop.
module tb_demux_1to2_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          pop0 = 1'b0;
    logic          pop1 = 1'b0;
    logic [DW-1:0] data_out0, data_out1;
    logic          valid_out0, valid_out1, full0, full1, lane_sel;
    logic          err_overflow, err_underflow;
`ifdef DEMUX_ALMOST_FULL_EN
    logic          almost_full0, almost_full1;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            m_sel, m_ovf, m_unf;

    demux_1to2_fifo dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .pop0          (pop0),
        .pop1          (pop1),
        .data_out0     (data_out0),
        .data_out1     (data_out1),
        .valid_out0    (valid_out0),
        .valid_out1    (valid_out1),
        .full0         (full0),
        .full1         (full1),
        .lane_sel      (lane_sel),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`ifdef DEMUX_ALMOST_FULL_EN
        ,
        .almost_full0  (almost_full0),
        .almost_full1  (almost_full1)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, then update the scoreboard for the edge: pops first, then push.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit p0, input bit p1);
        valid_in = v;
        data_in  = d;
        pop0     = p0;
        pop1     = p1;
        @(posedge clk);
        if (p0) begin
            if (q0.size() > 0) void'(q0.pop_front());
            else m_unf = 1'b1;
        end
        if (p1) begin
            if (q1.size() > 0) void'(q1.pop_front());
            else m_unf = 1'b1;
        end
        if (v) begin
            if (!m_sel) begin
                if (q0.size() < DEPTH) q0.push_back(d);
                else m_ovf = 1'b1;
            end else begin
                if (q1.size() < DEPTH) q1.push_back(d);
                else m_ovf = 1'b1;
            end
            m_sel = ~m_sel;
        end
        #1;
        valid_in = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        q0.delete();
        q1.delete();
        m_sel = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        apply_reset();
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        outs = {data_out0, data_out1, valid_out0, valid_out1, full0, full1,
                lane_sel, err_overflow, err_underflow};
        n_total++;
        if (outs !== '0) $display("FAIL reset_idle outputs=%h expected=0", outs);
        else n_pass++;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h6B, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++;
        if (!(valid_out0 && err_underflow)) $display("FAIL reset_prestate valid_out0=%b err_underflow=%b expected 1,1", valid_out0, err_underflow);
        else n_pass++;
        #2 reset_L = 1'b0;
        #1;
        outs = {data_out0, data_out1, valid_out0, valid_out1, full0, full1,
                lane_sel, err_overflow, err_underflow};
        n_total++;
        if (outs !== '0) $display("FAIL reset_async outputs=%h expected=0", outs);
        else n_pass++;
        #3 apply_reset();
    endtask

    task automatic test_stream();
        logic [DW-1:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1'b1, bytes[0], 1'b0, 1'b0);
        n_total++;
        if (data_out0 !== 8'h11 || valid_out0 !== 1'b1 || valid_out1 !== 1'b0)
            $display("FAIL stream_first data_out0=%h v0=%b v1=%b expected 11,1,0", data_out0, valid_out0, valid_out1);
        else n_pass++;
        step(1'b1, bytes[1], 1'b0, 1'b0);
        n_total++;
        if (data_out1 !== 8'h22 || data_out0 !== 8'h11)
            $display("FAIL stream_second data_out1=%h data_out0=%h expected 22,11", data_out1, data_out0);
        else n_pass++;
        step(1'b1, bytes[2], 1'b0, 1'b0);
        step(1'b1, bytes[3], 1'b0, 1'b0);
        while (q0.size() > 0) begin
            n_total++;
            if (data_out0 !== q0[0]) $display("FAIL stream_lane0 data_out0=%h expected=%h", data_out0, q0[0]);
            else n_pass++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        while (q1.size() > 0) begin
            n_total++;
            if (data_out1 !== q1[0]) $display("FAIL stream_lane1 data_out1=%h expected=%h", data_out1, q1[0]);
            else n_pass++;
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_total++;
        if ({valid_out0, valid_out1, data_out0, data_out1} !== '0)
            $display("FAIL stream_drained v0=%b v1=%b d0=%h d1=%h expected all 0", valid_out0, valid_out1, data_out0, data_out1);
        else n_pass++;
    endtask

    task automatic test_gaps();
        step(1'b1, 8'hA0, 1'b0, 1'b0);
        step(1'b0, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'hEE, 1'b0, 1'b0);
        n_total++;
        if (lane_sel !== 1'b1) $display("FAIL gaps_hold lane_sel=%b expected=1", lane_sel);
        else n_pass++;
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        n_total++;
        if (data_out0 !== 8'hA0 || data_out1 !== 8'hA1 || lane_sel !== 1'b0)
            $display("FAIL gaps_lanes d0=%h d1=%h sel=%b expected a0,a1,0", data_out0, data_out1, lane_sel);
        else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        n_total++;
        if (full0 !== 1'b1 || full1 !== 1'b1 || err_overflow !== 1'b0)
            $display("FAIL ovf_filled full0=%b full1=%b err_overflow=%b expected 1,1,0", full0, full1, err_overflow);
        else n_pass++;
        step(1'b1, 8'h08, 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b0, 1'b0);
        n_total++;
        if (err_overflow !== 1'b1 || lane_sel !== 1'b0)
            $display("FAIL ovf_flag err_overflow=%b lane_sel=%b expected 1,0", err_overflow, lane_sel);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (data_out0 !== 8'(2 * i)) $display("FAIL ovf_lane0 data_out0=%h expected=%h", data_out0, 8'(2 * i));
            else n_pass++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        while (q1.size() > 0) begin
            n_total++;
            if (data_out1 !== q1[0]) $display("FAIL ovf_lane1 data_out1=%h expected=%h", data_out1, q1[0]);
            else n_pass++;
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_total++;
        if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0)
            $display("FAIL ovf_drained v0=%b v1=%b expected 0,0", valid_out0, valid_out1);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        logic [DW-1:0] exp0 [4] = '{8'h22, 8'h24, 8'h26, 8'h30};
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        n_total++;
        if (data_out0 !== 8'h20) $display("FAIL pp_head data_out0=%h expected=20", data_out0);
        else n_pass++;
        step(1'b1, 8'h30, 1'b1, 1'b0);
        n_total++;
        if (full0 !== 1'b1 || err_overflow !== 1'b0 || data_out0 !== 8'h22)
            $display("FAIL pp_full full0=%b err_overflow=%b data_out0=%h expected 1,0,22", full0, err_overflow, data_out0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (data_out0 !== exp0[i]) $display("FAIL pp_lane0 data_out0=%h expected=%h", data_out0, exp0[i]);
            else n_pass++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_underflow();
        while (q1.size() > 0) begin
            n_total++;
            if (data_out1 !== q1[0]) $display("FAIL unf_drain data_out1=%h expected=%h", data_out1, q1[0]);
            else n_pass++;
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_total++;
        if (err_underflow !== 1'b0) $display("FAIL unf_before err_underflow=%b expected=0", err_underflow);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++;
        if (err_underflow !== 1'b1 || valid_out1 !== 1'b0 || data_out1 !== 8'h00)
            $display("FAIL unf_flag err_underflow=%b v1=%b d1=%h expected 1,0,00", err_underflow, valid_out1, data_out1);
        else n_pass++;
        step(1'b1, 8'h55, 1'b0, 1'b0);
        n_total++;
        if (data_out1 !== 8'h55 || valid_out1 !== 1'b1 || lane_sel !== 1'b0 || err_underflow !== 1'b1)
            $display("FAIL unf_ptrs d1=%h v1=%b sel=%b err_underflow=%b expected 55,1,0,1", data_out1, valid_out1, lane_sel, err_underflow);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, want;
        for (int i = 0; i < 60; i++) begin
            bit v, p0, p1;
            logic [DW-1:0] d;
            v  = ($urandom_range(3) != 0);
            p0 = ($urandom_range(2) == 0);
            p1 = ($urandom_range(2) == 0);
            d  = 8'($urandom);
            if (p0 && q0.size() > 0) begin
                n_total++;
                if (data_out0 !== q0[0]) $display("FAIL b2b_pop0 data_out0=%h expected=%h", data_out0, q0[0]);
                else n_pass++;
            end
            if (p1 && q1.size() > 0) begin
                n_total++;
                if (data_out1 !== q1[0]) $display("FAIL b2b_pop1 data_out1=%h expected=%h", data_out1, q1[0]);
                else n_pass++;
            end
            step(v, d, p0, p1);
            got  = {valid_out0, full0, valid_out1, full1, lane_sel};
            want = {q0.size() != 0, q0.size() == DEPTH, q1.size() != 0, q1.size() == DEPTH, m_sel};
            n_total++;
            if (got !== want) $display("FAIL b2b_status got=%b expected=%b", got, want);
            else n_pass++;
        end
        n_total++;
        if (err_overflow !== m_ovf || err_underflow !== m_unf)
            $display("FAIL b2b_errs ovf=%b unf=%b expected %b,%b", err_overflow, err_underflow, m_ovf, m_unf);
        else n_pass++;
    endtask

`ifdef DEMUX_ALMOST_FULL_EN
    task automatic test_almost_full();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        n_total++;
        if (almost_full0 !== 1'b0 || almost_full1 !== 1'b0)
            $display("FAIL af_two af0=%b af1=%b expected 0,0", almost_full0, almost_full1);
        else n_pass++;
        step(1'b1, 8'h74, 1'b0, 1'b0);
        n_total++;
        if (almost_full0 !== 1'b1 || almost_full1 !== 1'b0)
            $display("FAIL af_three af0=%b af1=%b expected 1,0", almost_full0, almost_full1);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_overflow();
        test_full_pushpop();
        test_underflow();
        test_back_to_back();
`ifdef DEMUX_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
